serial_full_sub: RTL and testbench

//  Bit-serial subtractor: computes diff = a - b over WIDTH clocks, LSB first.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_full_sub_if.sv | 21 ++
 rtl/full_sub.sv | 11 +
 rtl/serial_full_sub.sv | 118 +++++++++++
 tb/tb_serial_full_sub.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and sizing helper for the bit-serial subtractor
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_full_sub_if.sv
// rtl/serial_full_sub_if.sv - start/done operand and result bundle; ovf present with SERIAL_SUB_OVF_EN
interface serial_full_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit combinational full subtractor cell
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_full_sub.sv
// rtl/serial_full_sub.sv - LSB-first bit-serial a-b over WIDTH clocks; SERIAL_SUB_OVF_EN adds signed overflow
module serial_full_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                clk,
    input logic                rst,
    serial_full_sub_if.slave   bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt;
    logic             bw;
    logic             borrow_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bout;

    full_sub u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result registers only change when leaving DONE, so diff survives a new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        bw  <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= {cell_d, acc[WIDTH-1:1]};
                    bw  <= cell_bout;
                    cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    done_q   <= 1'b1;
                    diff_q   <= acc;
                    borrow_q <= bw;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Signed overflow: operand signs differ and the result sign departs from the minuend.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == S_DONE) begin
            ovf_q <= (a_msb != b_msb) && (acc[WIDTH-1] != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy       = (state == S_SHIFT);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_full_sub.sv
// tb/tb_serial_full_sub.sv - directed and random scoreboard bench for serial_full_sub
module tb_serial_full_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_full_sub_if #(.WIDTH(W)) bus ();

    serial_full_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;
    logic [W+1:0] sb_q[$];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; expected {ovf, borrow, diff} is queued as the operands go out.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] r;
        logic       ov;
        r  = {1'b0, av} - {1'b0, bv};
        ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        sb_q.push_back({ov, r});
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        logic [W+1:0] e;
        int n;
        n        = 0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        lat = n;
        if (bus.done !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(bus.done), 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_diff"}, 32'(bus.diff), 32'(e[W-1:0]));
        chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e[W+1]));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        start_op(8'd5, 8'd3);
        wait_done("t1");
        chk("t1_latency", 32'(lat), 32'd9);

        start_op(8'd3, 8'd5);
        wait_done("t2");
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd8);

        start_op(8'h80, 8'h01);
        wait_done("t3");
        repeat (3) @(negedge clk);
        chk("t3_diff_held", 32'(bus.diff), 32'h7F);

        start_op(8'h10, 8'h01);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t4");
        start_op(8'h9C, 8'h27);
        wait_done("t4b2b1");
        start_op(8'h5A, 8'h5A);
        wait_done("t4eq");
        start_op(8'h00, 8'h01);
        wait_done("t4neg");

        start_op(8'h37, 8'h12);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_diff", 32'(bus.diff), 32'd0);
        chk("t5_borrow", 32'(bus.borrow_out), 32'd0);
        rst = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        start_op(8'h00, 8'h00);
        wait_done("t5zero");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            start_op(ra, rb);
            wait_done("rnd");
        end
        @(negedge clk);
        chk("final_done_low", 32'(bus.done), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
